// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// It runs a 32-step shift-add multiply or restoring divide and stalls the pipeline while it works.
module ex_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic [4:0]            rd_in,
  input  logic                  flush,
  output logic                  busy,
  output logic                  stall_req,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [4:0]            rd_out
);

  // state | meaning
  // IDLE  | waiting for an M-extension op; special cases resolve here
  // CALC  | one multiply/divide iteration per clock, 32 in total
  // DONE  | result valid for this single cycle
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int W = DATA_WIDTH;
  localparam logic [5:0] LAST_ITER = 6'(W - 1);

  state_t state, state_nxt;

  logic [2:0]     op_q;
  logic           a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic [5:0]     cnt;
  logic [2*W-1:0] acc, acc_nxt, prod_s;
  logic [W:0]     mul_sum, div_shift, div_diff;
  logic [W-1:0]   quot_s, rem_s, res_final;

  logic           sgn_a, sgn_b, a_neg_in, b_neg_in, div_zero, div_ovf, special;
  logic [W-1:0]   a_mag_in, b_mag_in, special_res;
  logic           accept, last;

  // Operand decode and the cases that never enter the iterative loop
  always_comb begin
    sgn_a    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    sgn_b    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg_in = sgn_a & src_a[W-1];
    b_neg_in = sgn_b & src_b[W-1];
    a_mag_in = a_neg_in ? -src_a : src_a;
    b_mag_in = b_neg_in ? -src_b : src_b;
    div_zero = funct3[2] && (src_b == '0);
    div_ovf  = funct3[2] && !funct3[0] && (src_a == {1'b1, {(W-1){1'b0}}}) && (src_b == '1);
    special  = div_zero | div_ovf;
    if (div_zero)
      special_res = funct3[1] ? src_a : '1;
    else
      special_res = funct3[1] ? '0 : src_a;
  end

  // One iteration step plus the sign-corrected view of its outcome
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a_mag} : '0);
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_diff  = div_shift - {1'b0, b_mag};
    if (op_q[2]) begin
      if (!div_diff[W])
        acc_nxt = {div_diff[W-1:0], acc[W-2:0], 1'b1};
      else
        acc_nxt = {div_shift[W-1:0], acc[W-2:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc[W-1:1]};
    end
    prod_s = (a_neg ^ b_neg) ? -acc_nxt : acc_nxt;
    quot_s = (a_neg ^ b_neg) ? -acc_nxt[W-1:0] : acc_nxt[W-1:0];
    rem_s  = a_neg ? -acc_nxt[2*W-1:W] : acc_nxt[2*W-1:W];
    case (op_q)
      3'b000:                 res_final = prod_s[W-1:0];
      3'b001, 3'b010, 3'b011: res_final = prod_s[2*W-1:W];
      3'b100, 3'b101:         res_final = quot_s;
      default:                res_final = rem_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          accept    = 1'b1;
          state_nxt = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (cnt == LAST_ITER) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy      = (state != IDLE);
    done      = (state == DONE);
    stall_req = ((state == IDLE) && start && !flush) || (state == CALC);
  end

  // Divide keeps the dividend in the low half; multiply keeps the multiplier there
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      a_mag  <= '0;
      b_mag  <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      rd_out <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      op_q   <= funct3;
      rd_out <= rd_in;
      a_neg  <= a_neg_in;
      b_neg  <= b_neg_in;
      a_mag  <= a_mag_in;
      b_mag  <= b_mag_in;
      acc    <= {{W{1'b0}}, (funct3[2] ? a_mag_in : b_mag_in)};
      cnt    <= '0;
      if (special) result <= special_res;
    end else if (state == CALC) begin
      acc <= acc_nxt;
      cnt <= cnt + 6'd1;
      if (last) result <= res_final;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized self-checking bench for ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] src_a, src_b, result;
  logic [4:0]  rd_in, rd_out;
  logic        busy, stall_req, done;

  int          total = 0;
  int          bad = 0;
  logic [31:0] last_res = '0;

  ex_muldiv #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .src_a     (src_a),
    .src_b     (src_b),
    .rd_in     (rd_in),
    .flush     (flush),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, p;
    logic [63:0] pu;
    int          ia, ib;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed({32'b0, b}); return p[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op as the pipeline would: start held until done, then back-to-back ready
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] exp;
    int          lat, stalls, n_exp;
    bit          seen;
    exp    = ref_model(f, a, b);
    n_exp  = is_special(f, a, b) ? 1 : 33;
    funct3 = f;
    src_a  = a;
    src_b  = b;
    rd_in  = rd;
    start  = 1'b1;
    #1;
    stalls = int'(stall_req);
    lat    = 0;
    seen   = 1'b0;
    while (!seen && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) seen = 1'b1;
      else stalls += int'(stall_req);
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_latency"}, 32'(lat), 32'(n_exp));
      chk({tag, "_stall_cycles"}, 32'(stalls), 32'(n_exp));
      chk({tag, "_stall_in_done"}, 32'(stall_req), 32'd0);
      chk({tag, "_result"}, result, exp);
      chk({tag, "_rd_out"}, 32'(rd_out), 32'(rd));
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, result, exp);
    last_res = exp;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = '0; src_a = '0; src_b = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd_out", 32'(rd_out), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    rst = 1'b0;

    run_op("mul", 3'd0, 32'h7, 32'hFFFF_FFFD, 5'd5);
    chk("mul_literal", last_res, 32'hFFFF_FFEB);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1);
    run_op("mulhsu", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2);
    run_op("mulhu", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'h2, 5'd4);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'h2, 5'd6);
    run_op("divu", 3'd5, 32'd100, 32'd7, 5'd7);
    run_op("remu", 3'd7, 32'd100, 32'd7, 5'd8);
    run_op("div_by0", 3'd4, 32'd5, 32'd0, 5'd9);
    run_op("rem_by0", 3'd6, 32'd5, 32'd0, 5'd10);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);

    // Abort a divide partway through
    funct3 = 3'd4; src_a = 32'd1000; src_b = 32'd7; rd_in = 5'd13; start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    chk("flush_result", result, last_res);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      pulses += int'(done);
    end
    chk("flush_no_done", 32'(pulses), 32'd0);
    run_op("mulhu_after_flush", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14);
    chk("mulhu_after_flush_literal", last_res, 32'hFFFF_FFFE);

    // Reset in the middle of an op
    funct3 = 3'd0; src_a = 32'd123; src_b = 32'd456; rd_in = 5'd15; start = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_rd_out", 32'(rd_out), 32'd0);
    rst = 1'b0;
    last_res = '0;

    // flush together with start in IDLE rejects the op
    funct3 = 3'd0; src_a = 32'd3; src_b = 32'd4; rd_in = 5'd16;
    start = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_start_stall", 32'(stall_req), 32'd0);
    @(posedge clk);
    #1;
    chk("flush_start_busy", 32'(busy), 32'd0);
    start = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #1;
    chk("flush_start_idle", 32'(busy), 32'd0);
    chk("flush_start_result", result, 32'd0);

    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), pick(), pick(),
             5'($urandom_range(0, 31)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
